// File: rtl/vs_stream_ctrl.sv
// vs_stream_ctrl: VS10xx codec streamer - SDI track playback, queued SCI commands, codec hard reset.
// Optional SCI register read-back (rd_data/rd_valid) is built when VS_SCI_READ_EN is defined.
//
// state     | meaning
// RST_HOLD  | MP3_RSET held low for RST_CYCLES
// RST_WAIT  | reset released, waiting for DREQ
// IDLE      | choose next SCI command or SDI word
// SCI_LOAD  | pop FIFO into shifter, CS low
// SDI_FETCH | memory read latency, then load word, DCS low
// SHIFT     | clock the word out on SCLK/MOSI
// GAP       | selects high for one SCLK half-period
module vs_stream_ctrl #(
  parameter int NCH        = 7,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 13,
  parameter int TRACK_LEN  = 8192,
  parameter int SCLK_DIV   = 4,
  parameter int RST_CYCLES = 100000,
  parameter int FIFO_DEPTH = 4,
  localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk_cpu,
  input  logic                  RESET,
  input  logic                  cmd_we,
  input  logic [31:0]           cmd_wdata,
  output logic                  cmd_full,
  input  logic                  trk_we,
  input  logic [CH_W-1:0]       trk_wdata,
  input  logic                  play_en,
  input  logic                  loop_en,
  output logic [ADDR_W-1:0]     src_addr,
  input  logic [NCH*DATA_W-1:0] src_data,
  output logic [CH_W-1:0]       cur_trk,
  output logic [ADDR_W-1:0]     word_cnt,
  output logic                  trk_done,
  output logic                  busy,
  output logic                  MP3_RSET,
  output logic                  MP3_CS,
  output logic                  MP3_DCS,
  output logic                  MP3_SCLK,
  output logic                  MP3_MOSI,
  input  logic                  MP3_DREQ,
`ifdef VS_SCI_READ_EN
  output logic [15:0]           rd_data,
  output logic                  rd_valid,
`endif
  input  logic                  MP3_MISO
);

  localparam int SH_W   = (DATA_W > 32) ? DATA_W : 32;
  localparam int BIT_W  = $clog2(SH_W + 1);
  localparam int DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(SCLK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(TRACK_LEN - 1);

  typedef enum logic [2:0] {
    RST_HOLD, RST_WAIT, IDLE, SCI_LOAD, SDI_FETCH, SHIFT, GAP
  } state_t;

  state_t state_q, state_d;

  logic [HOLD_W-1:0] hold_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bits_left;
  logic [SH_W-1:0]   sh;
  logic              is_sdi;
  logic              stopped;

  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;

  logic              trk_chg, fifo_empty, push, pop, div_tc, sclk_rise, word_end;
  logic [DATA_W-1:0] sdi_word;
  logic [SH_W-1:0]   sci_vec, sdi_vec;

  // A track switch only counts when it names a different, existing track.
  assign trk_chg    = trk_we && (trk_wdata != cur_trk) && (int'(trk_wdata) < NCH);
  assign cmd_full   = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign push       = cmd_we && !cmd_full && !trk_chg;
  assign pop        = (state_q == SCI_LOAD) && !trk_chg;
  assign div_tc     = (div_cnt == '0);
  assign sclk_rise  = (state_q == SHIFT) && div_tc && !MP3_SCLK && !trk_chg;
  assign word_end   = (state_q == SHIFT) && div_tc && MP3_SCLK && (bits_left == '0) && !trk_chg;

  assign sdi_word = src_data[int'(cur_trk)*DATA_W +: DATA_W];
  assign sci_vec  = SH_W'(fifo_mem[rd_ptr]) << (SH_W - 32);
  assign sdi_vec  = SH_W'(sdi_word) << (SH_W - DATA_W);

  assign MP3_MOSI = sh[SH_W-1];
  assign word_cnt = src_addr;
  assign busy     = (state_q != IDLE);

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_cpu or negedge RESET) begin
    if (!RESET) state_q <= RST_HOLD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (trk_chg) begin
      state_d = RST_HOLD;
    end else begin
      case (state_q)
        RST_HOLD:  if (hold_cnt == HOLD_LAST) state_d = RST_WAIT;
        RST_WAIT:  if (MP3_DREQ) state_d = IDLE;
        IDLE: begin
          if (!fifo_empty && MP3_DREQ)                state_d = SCI_LOAD;
          else if (play_en && MP3_DREQ && !stopped)   state_d = SDI_FETCH;
        end
        SCI_LOAD:  state_d = SHIFT;
        SDI_FETCH: state_d = SHIFT;
        SHIFT:     if (word_end) state_d = GAP;
        GAP:       if (div_tc) state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (push) fifo_mem[wr_ptr] <= cmd_wdata;
  end

  always_ff @(posedge clk_cpu or negedge RESET) begin
    if (!RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (trk_chg) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_cpu or negedge RESET) begin
    if (!RESET) begin
      hold_cnt  <= '0;
      div_cnt   <= '0;
      bits_left <= '0;
      sh        <= '0;
      is_sdi    <= 1'b0;
      stopped   <= 1'b0;
      src_addr  <= '0;
      cur_trk   <= '0;
      trk_done  <= 1'b0;
      MP3_RSET  <= 1'b0;
      MP3_CS    <= 1'b1;
      MP3_DCS   <= 1'b1;
      MP3_SCLK  <= 1'b0;
    end else begin
      trk_done <= 1'b0;
      if (trk_chg) begin
        cur_trk  <= trk_wdata;
        src_addr <= '0;
        stopped  <= 1'b0;
        hold_cnt <= '0;
        sh       <= '0;
        MP3_RSET <= 1'b0;
        MP3_CS   <= 1'b1;
        MP3_DCS  <= 1'b1;
        MP3_SCLK <= 1'b0;
      end else begin
        case (state_q)
          RST_HOLD: begin
            if (hold_cnt == HOLD_LAST) MP3_RSET <= 1'b1;
            else                       hold_cnt <= hold_cnt + 1'b1;
          end
          SCI_LOAD: begin
            sh        <= sci_vec;
            bits_left <= BIT_W'(32);
            div_cnt   <= DIV_LOAD;
            is_sdi    <= 1'b0;
            MP3_CS    <= 1'b0;
            MP3_SCLK  <= 1'b0;
          end
          SDI_FETCH: begin
            sh        <= sdi_vec;
            bits_left <= BIT_W'(DATA_W);
            div_cnt   <= DIV_LOAD;
            is_sdi    <= 1'b1;
            MP3_DCS   <= 1'b0;
            MP3_SCLK  <= 1'b0;
          end
          SHIFT: begin
            if (div_tc) begin
              div_cnt <= DIV_LOAD;
              if (!MP3_SCLK) begin
                MP3_SCLK  <= 1'b1;
                bits_left <= bits_left - 1'b1;
              end else if (bits_left == '0) begin
                MP3_SCLK <= 1'b0;
                MP3_CS   <= 1'b1;
                MP3_DCS  <= 1'b1;
                sh       <= '0;
                if (is_sdi) begin
                  if (src_addr == ADDR_LAST) begin
                    trk_done <= 1'b1;
                    src_addr <= '0;
                    if (!loop_en) stopped <= 1'b1;
                  end else begin
                    src_addr <= src_addr + 1'b1;
                  end
                end
              end else begin
                MP3_SCLK <= 1'b0;
                sh       <= sh << 1;
              end
            end else begin
              div_cnt <= div_cnt - 1'b1;
            end
          end
          GAP: if (!div_tc) div_cnt <= div_cnt - 1'b1;
          default: ;
        endcase
      end
    end
  end

`ifdef VS_SCI_READ_EN
  logic is_read;

  // Read data occupies the low 16 bits of the frame, i.e. the last 16 rising edges.
  always_ff @(posedge clk_cpu or negedge RESET) begin
    if (!RESET) begin
      is_read  <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (trk_chg) begin
        is_read <= 1'b0;
      end else if (state_q == SCI_LOAD) begin
        is_read <= (fifo_mem[rd_ptr][31:24] == 8'h03);
      end else begin
        if (sclk_rise && is_read && (bits_left <= BIT_W'(16)))
          rd_data <= {rd_data[14:0], MP3_MISO};
        if (word_end && is_read) begin
          rd_valid <= 1'b1;
          is_read  <= 1'b0;
        end
      end
    end
  end
`else
  logic unused_miso;
  logic unused_rise;
  assign unused_miso = MP3_MISO;
  assign unused_rise = sclk_rise;
`endif

endmodule

// File: tb/tb_vs_stream_ctrl.sv
// Self-checking bench for vs_stream_ctrl: SCI FIFO, SDI playback, track switching, DREQ gating.
module tb_vs_stream_ctrl;

  localparam int NCH = 7;
  localparam int DW  = 16;
  localparam int AW  = 13;
  localparam int CW  = 3;

  logic            clk_cpu = 1'b0;
  logic            RESET;
  logic            cmd_we;
  logic [31:0]     cmd_wdata;
  logic            cmd_full;
  logic            trk_we;
  logic [CW-1:0]   trk_wdata;
  logic            play_en, loop_en;
  logic [AW-1:0]   src_addr, word_cnt;
  logic [NCH*DW-1:0] src_data;
  logic [CW-1:0]   cur_trk;
  logic            trk_done, busy;
  logic            MP3_RSET, MP3_CS, MP3_DCS, MP3_SCLK, MP3_MOSI;
  logic            MP3_DREQ, MP3_MISO;

  always #5 clk_cpu = ~clk_cpu;

  vs_stream_ctrl #(
    .NCH(NCH), .DATA_W(DW), .ADDR_W(AW), .TRACK_LEN(4),
    .SCLK_DIV(1), .RST_CYCLES(16), .FIFO_DEPTH(4)
  ) dut (
    .clk_cpu(clk_cpu), .RESET(RESET),
    .cmd_we(cmd_we), .cmd_wdata(cmd_wdata), .cmd_full(cmd_full),
    .trk_we(trk_we), .trk_wdata(trk_wdata),
    .play_en(play_en), .loop_en(loop_en),
    .src_addr(src_addr), .src_data(src_data),
    .cur_trk(cur_trk), .word_cnt(word_cnt),
    .trk_done(trk_done), .busy(busy),
    .MP3_RSET(MP3_RSET), .MP3_CS(MP3_CS), .MP3_DCS(MP3_DCS),
    .MP3_SCLK(MP3_SCLK), .MP3_MOSI(MP3_MOSI),
    .MP3_DREQ(MP3_DREQ), .MP3_MISO(MP3_MISO)
  );

  // Track memories with one cycle of read latency.
  logic [15:0] mem [NCH][4];
  initial begin
    for (int k = 0; k < NCH; k++)
      for (int a = 0; a < 4; a++)
        mem[k][a] = 16'(16'h1000 * k + 16'h0100 * a + 16'h00C3);
    mem[2][0] = 16'hA55A;
    mem[2][1] = 16'h1234;
    mem[2][2] = 16'h0FF0;
    mem[2][3] = 16'hC3C3;
    src_data = '0;
    forever begin
      @(posedge clk_cpu);
      for (int k = 0; k < NCH; k++) src_data[k*DW +: DW] <= mem[k][src_addr[1:0]];
    end
  end

  typedef struct {
    logic        sdi;
    logic [31:0] data;
    int          nbits;
  } frame_t;

  typedef struct {
    logic        we;
    logic [31:0] wdata;
    logic        exp_full;
  } push_vec_t;

  // Codec-side monitor: one record per CS/DCS-low frame.
  frame_t frq[$];
  logic        in_frame = 1'b0;
  logic        cur_sdi, sclk_prev = 1'b0;
  logic [31:0] acc;
  int          nb, sdi_frames = 0, done_cnt = 0, done_at = 0, overlap_cnt = 0;

  initial begin
    forever begin
      @(negedge clk_cpu);
      if (!MP3_CS && !MP3_DCS) overlap_cnt++;
      if (!in_frame && (!MP3_CS || !MP3_DCS)) begin
        in_frame = 1'b1;
        cur_sdi  = !MP3_DCS;
        acc      = '0;
        nb       = 0;
      end
      if (in_frame && MP3_SCLK && !sclk_prev) begin
        acc = {acc[30:0], MP3_MOSI};
        nb++;
      end
      if (in_frame && MP3_CS && MP3_DCS) begin
        frq.push_back('{cur_sdi, acc, nb});
        if (cur_sdi) sdi_frames++;
        in_frame = 1'b0;
      end
      if (trk_done) begin
        done_cnt++;
        done_at = sdi_frames;
      end
      sclk_prev = MP3_SCLK;
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_frame(input string name, input int idx, input frame_t exp);
    if (idx >= frq.size()) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: frame %0d missing, got %0d frames", name, idx, frq.size());
    end else begin
      chk({name, "_sel"},  32'(frq[idx].sdi),   32'(exp.sdi));
      chk({name, "_bits"}, 32'(frq[idx].nbits), 32'(exp.nbits));
      chk({name, "_data"}, frq[idx].data,       exp.data);
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget && frq.size() < n; i++) @(negedge clk_cpu);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clk_cpu);
  endtask

  push_vec_t pv [5];
  frame_t    exp1 [4];
  int        base;

  initial begin
    pv[0] = '{1'b1, 32'h02000804, 1'b0};
    pv[1] = '{1'b1, 32'h020B2020, 1'b0};
    pv[2] = '{1'b1, 32'h0203C000, 1'b0};
    pv[3] = '{1'b1, 32'h02051234, 1'b1};
    pv[4] = '{1'b1, 32'hDEADBEEF, 1'b1};
    for (int i = 0; i < 4; i++) exp1[i] = '{1'b0, pv[i].wdata, 32};

    RESET = 1'b0; cmd_we = 1'b0; cmd_wdata = '0; trk_we = 1'b0; trk_wdata = '0;
    play_en = 1'b0; loop_en = 1'b0; MP3_DREQ = 1'b1; MP3_MISO = 1'b0;

    repeat (3) @(negedge clk_cpu);
    chk("rst_rset",  32'(MP3_RSET), 32'd0);
    chk("rst_cs",    32'(MP3_CS),   32'd1);
    chk("rst_dcs",   32'(MP3_DCS),  32'd1);
    chk("rst_sclk",  32'(MP3_SCLK), 32'd0);
    chk("rst_mosi",  32'(MP3_MOSI), 32'd0);
    chk("rst_addr",  32'(src_addr), 32'd0);
    chk("rst_trk",   32'(cur_trk),  32'd0);
    chk("rst_done",  32'(trk_done), 32'd0);
    chk("rst_full",  32'(cmd_full), 32'd0);
    chk("rst_busy",  32'(busy),     32'd1);

    // Fill the FIFO during the reset hold; fifth push must be dropped.
    RESET = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmd_we = pv[i].we; cmd_wdata = pv[i].wdata;
      @(posedge clk_cpu); #1;
      chk($sformatf("push%0d_full", i), 32'(cmd_full), 32'(pv[i].exp_full));
    end
    cmd_we = 1'b0;
    repeat (10) @(posedge clk_cpu);
    #1 chk("rset_at_15", 32'(MP3_RSET), 32'd0);
    @(posedge clk_cpu);
    #1 chk("rset_at_16", 32'(MP3_RSET), 32'd1);
    @(negedge clk_cpu);

    wait_frames(4, 2000);
    repeat (40) @(negedge clk_cpu);
    chk("sci_frame_count", 32'(frq.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk_frame($sformatf("sci%0d", i), i, exp1[i]);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_cs",   32'(MP3_CS), 32'd1);
    chk("idle_dcs",  32'(MP3_DCS), 32'd1);

    // Track 2, no looping: four words then stop.
    base = frq.size();
    trk_we = 1'b1; trk_wdata = 3'd2;
    @(posedge clk_cpu); #1;
    chk("t2_trk",  32'(cur_trk),  32'd2);
    chk("t2_rset", 32'(MP3_RSET), 32'd0);
    chk("t2_addr", 32'(src_addr), 32'd0);
    trk_we = 1'b0; play_en = 1'b1; loop_en = 1'b0;
    @(negedge clk_cpu);
    wait_frames(base + 4, 1000);
    repeat (150) @(negedge clk_cpu);
    chk("t2_frame_count", 32'(frq.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      chk_frame($sformatf("t2w%0d", i), base + i, '{1'b1, {16'h0, mem[2][i]}, 16});
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);
    chk("t2_done_at",  32'(done_at),  32'(sdi_frames));
    chk("t2_stop_busy", 32'(busy), 32'd0);

    // Track 3 with looping, then switch to track 5 in the middle of a word.
    base = frq.size();
    trk_we = 1'b1; trk_wdata = 3'd3; loop_en = 1'b1;
    @(negedge clk_cpu);
    trk_we = 1'b0;
    wait_frames(base + 5, 2000);
    for (int i = 0; i < 5; i++)
      chk_frame($sformatf("t3w%0d", i), base + i, '{1'b1, {16'h0, mem[3][i % 4]}, 16});
    chk("t3_done_cnt", 32'(done_cnt), 32'd2);
    for (int i = 0; i < 100 && !(in_frame && !MP3_DCS); i++) @(negedge clk_cpu);
    repeat (10) @(negedge clk_cpu);
    chk("mid_dcs_low", 32'(MP3_DCS), 32'd0);
    trk_we = 1'b1; trk_wdata = 3'd5; play_en = 1'b0;
    @(posedge clk_cpu); #1;
    chk("sw_dcs",  32'(MP3_DCS),  32'd1);
    chk("sw_rset", 32'(MP3_RSET), 32'd0);
    chk("sw_addr", 32'(src_addr), 32'd0);
    chk("sw_trk",  32'(cur_trk),  32'd5);
    chk("sw_sclk", 32'(MP3_SCLK), 32'd0);
    @(negedge clk_cpu);
    trk_we = 1'b0;
    wait_idle(200);
    chk("t5_busy", 32'(busy), 32'd0);

    // Same index and out-of-range index are both ignored.
    trk_we = 1'b1; trk_wdata = 3'd5;
    @(negedge clk_cpu);
    trk_wdata = 3'd7;
    @(negedge clk_cpu);
    trk_we = 1'b0;
    @(negedge clk_cpu);
    chk("ign_trk",  32'(cur_trk),  32'd5);
    chk("ign_rset", 32'(MP3_RSET), 32'd1);
    chk("ign_busy", 32'(busy),     32'd0);

    // DREQ low holds off both kinds of traffic; SCI wins once DREQ returns.
    MP3_DREQ = 1'b0;
    cmd_we = 1'b1; cmd_wdata = 32'h0203ABCD;
    @(negedge clk_cpu);
    cmd_we = 1'b0; play_en = 1'b1; loop_en = 1'b0;
    base = frq.size();
    repeat (50) @(negedge clk_cpu);
    chk("dreq_no_frame", 32'(frq.size() - base), 32'd0);
    chk("dreq_cs",  32'(MP3_CS),  32'd1);
    chk("dreq_dcs", 32'(MP3_DCS), 32'd1);
    MP3_DREQ = 1'b1;
    wait_frames(base + 2, 500);
    play_en = 1'b0;
    chk_frame("prio_sci", base,     '{1'b0, 32'h0203ABCD, 32});
    chk_frame("prio_sdi", base + 1, '{1'b1, {16'h0, mem[5][0]}, 16});
    wait_idle(500);
    chk("end_busy", 32'(busy), 32'd0);
    chk("select_overlap", 32'(overlap_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
